// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Ports: clk, rst_n, start, bin[WIDTH] in; busy, done, bcd[4*DIGITS] out.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  // True when 10^d >= 2^w, i.e. d digits can hold every w-bit value.
  // p stops growing once it reaches the limit, so it cannot overflow.
  function automatic bit f_fits(input int w, input int d);
    logic [127:0] lim;
    logic [127:0] p;
    lim = 128'd1 << w;
    p   = 128'd1;
    for (int i = 0; i < d; i++) begin
      p = (p >= lim) ? p : p * 128'd10;
    end
    return (p >= lim);
  endfunction

  localparam bit FITS = (WIDTH >= 1) && (WIDTH <= 120)
                     && f_fits(WIDTH, DIGITS);

  if (!FITS) begin : g_bad_cfg
    $fatal(1, "bin2bcd_seq: DIGITS too small for WIDTH");
  end

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_scr;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [BW-1:0]    r_bcd;

  logic [BW-1:0]       w_adj;
  logic [BW+WIDTH-1:0] w_cat;
  logic [BW-1:0]       w_nscr;
  logic [WIDTH-1:0]    w_nbin;
  logic                w_last;

  // Per-nibble add-3; carries never cross nibble boundaries.
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    assign w_adj[4*k +: 4] = (r_scr[4*k +: 4] >= 4'd5)
                           ? r_scr[4*k +: 4] + 4'd3
                           : r_scr[4*k +: 4];
  end

  assign w_cat  = {w_adj, r_bin} << 1;
  assign w_nscr = w_cat[BW+WIDTH-1:WIDTH];
  assign w_nbin = w_cat[WIDTH-1:0];
  assign w_last = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_bin   <= bin;
            r_scr   <= '0;
            r_cnt   <= CW'(WIDTH - 1);
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_scr <= w_nscr;
          r_bin <= w_nbin;
          r_cnt <= r_cnt - 1'b1;
          if (w_last) begin
            r_bcd   <= w_nscr;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: 16-bit/5-digit and 8-bit/3-digit instances.
// Outputs are sampled on the falling edge; inputs are driven there too.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start16;
  logic [15:0] bin16;
  logic        busy16;
  logic        done16;
  logic [19:0] bcd16;
  logic        start8;
  logic [7:0]  bin8;
  logic        busy8;
  logic        done8;
  logic [11:0] bcd8;

  int n_chk;
  int n_fail;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .bin   (bin16),
    .busy  (busy16),
    .done  (done16),
    .bcd   (bcd16)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .bcd   (bcd8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Launches a conversion and returns result, done cycle and busy count.
  // Cycle 1 is the first falling edge after the edge that samples start.
  task automatic conv16(input  logic [15:0] v,
                        input  bit          now,
                        output logic [19:0] r,
                        output int          lat,
                        output int          nbusy);
    if (!now) @(negedge clk);
    start16 = 1'b1;
    bin16   = v;
    @(negedge clk);
    start16 = 1'b0;
    lat   = 0;
    nbusy = 0;
    for (int c = 1; c <= 40; c++) begin
      if (busy16) nbusy++;
      if (done16) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    r = bcd16;
  endtask

  task automatic conv8(input  logic [7:0]  v,
                       output logic [11:0] r,
                       output int          lat);
    @(negedge clk);
    start8 = 1'b1;
    bin8   = v;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      if (done8) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    r = bcd8;
  endtask

  logic [19:0] r16;
  logic [11:0] r8;
  int          lat;
  int          nb;
  int          ndone;
  int          dcyc;
  logic [15:0] rv;

  initial begin
    logic [15:0] vec_in  [4];
    logic [19:0] vec_exp [4];
    vec_in[0] = 16'd65535; vec_exp[0] = 20'h65535;
    vec_in[1] = 16'd9;     vec_exp[1] = 20'h00009;
    vec_in[2] = 16'd10;    vec_exp[2] = 20'h00010;
    vec_in[3] = 16'd1000;  vec_exp[3] = 20'h01000;

    n_chk   = 0;
    n_fail  = 0;
    clk     = 1'b0;
    rst_n   = 1'b0;
    start16 = 1'b0;
    bin16   = '0;
    start8  = 1'b0;
    bin8    = '0;

    #3;
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_done", 32'(done16), 32'd0);
    chk("rst_bcd", 32'(bcd16), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // bin = 0: latency and busy window
    conv16(16'd0, 1'b0, r16, lat, nb);
    chk("zero_bcd", 32'(r16), 32'h00000);
    chk("zero_lat", 32'(lat), 32'd17);
    chk("zero_busy_cycles", 32'(nb), 32'd16);
    chk("zero_busy_in_done", 32'(busy16), 32'd0);
    @(negedge clk);
    chk("zero_done_width", 32'(done16), 32'd0);

    for (int i = 0; i < 4; i++) begin
      conv16(vec_in[i], 1'b0, r16, lat, nb);
      chk($sformatf("vec%0d_bcd", i), 32'(r16), 32'(vec_exp[i]));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd17);
      @(negedge clk);
      chk($sformatf("vec%0d_done_w", i), 32'(done16), 32'd0);
      chk($sformatf("vec%0d_hold", i), 32'(bcd16), 32'(vec_exp[i]));
    end

    // 1234 with a second start while busy and bin churning
    @(negedge clk);
    start16 = 1'b1;
    bin16   = 16'd1234;
    ndone = 0;
    dcyc  = 0;
    r16   = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done16) begin
        ndone++;
        dcyc = c;
        r16  = bcd16;
      end
      start16 = (c == 5);
      bin16   = (c == 5) ? 16'd999 : 16'($urandom);
    end
    start16 = 1'b0;
    chk("busy_start_bcd", 32'(r16), 32'h01234);
    chk("busy_start_ndone", 32'(ndone), 32'd1);
    chk("busy_start_lat", 32'(dcyc), 32'd17);

    // back-to-back: second start in the done cycle
    conv16(16'd42, 1'b0, r16, lat, nb);
    chk("b2b_first", 32'(r16), 32'h00042);
    conv16(16'd58, 1'b1, r16, lat, nb);
    chk("b2b_second", 32'(r16), 32'h00058);
    chk("b2b_lat", 32'(lat), 32'd17);

    // reset in the middle of a conversion
    conv16(16'd777, 1'b0, r16, lat, nb);
    chk("pre_rst_bcd", 32'(r16), 32'h00777);
    @(negedge clk);
    start16 = 1'b1;
    bin16   = 16'd500;
    @(negedge clk);
    start16 = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", 32'(busy16), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy16), 32'd0);
    chk("abort_done", 32'(done16), 32'd0);
    chk("abort_bcd", 32'(bcd16), 32'd0);
    chk("abort_busy8", 32'(busy8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done16) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    conv16(16'd500, 1'b0, r16, lat, nb);
    chk("after_rst_500", 32'(r16), 32'h00500);

    // random sweep against the decimal reference
    for (int i = 0; i < 2000; i++) begin
      rv = 16'($urandom_range(0, 65535));
      conv16(rv, 1'b0, r16, lat, nb);
      chk($sformatf("sweep_%0d", rv), 32'(r16), ref_bcd(32'(rv)));
    end

    // 8-bit / 3-digit instance
    conv8(8'd255, r8, lat);
    chk("w8_255", 32'(r8), 32'h255);
    chk("w8_lat", 32'(lat), 32'd9);
    for (int v = 0; v < 256; v++) begin
      conv8(8'(v), r8, lat);
      chk($sformatf("w8_%0d", v), 32'(r8), ref_bcd(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
